// File: rtl/multi_pulse_generator_pkg.sv
// Shared types for the multi-channel pulse generator.
package pulse_pkg;

   // Channel operating mode, latched into the shadow at entry to RUN.
   typedef enum logic {
      PULSE_CONT  = 1'b0,
      PULSE_BURST = 1'b1
   } pulse_mode_t;

   // Per-channel FSM state.
   typedef enum logic {
      PULSE_IDLE = 1'b0,
      PULSE_RUN  = 1'b1
   } pulse_state_t;

endpackage

// File: rtl/multi_pulse_generator_channel.sv
// One pulse channel: IDLE/RUN FSM, period counter, shadowed period/width/mode,
// burst countdown and the out/busy/done outputs.
module pulse_channel
   import pulse_pkg::*;
#(
   parameter int N = 8,
   parameter int M = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         ch_ena,
   input  logic         mode,
   input  logic         start,
   input  logic [N-1:0] ticks,
   input  logic [N-1:0] width,
   input  logic [M-1:0] burst_len,
   output logic         out,
   output logic         busy,
   output logic         done
);

   pulse_state_t state_q, state_d;
   pulse_mode_t  sh_mode_q, sh_mode_d;
   logic [N-1:0] cnt_q, cnt_d;
   logic [N-1:0] sh_ticks_q, sh_ticks_d;
   logic [N-1:0] sh_width_q, sh_width_d;
   logic [M-1:0] rem_q, rem_d;
   logic         done_q, done_d;

   logic         wrap;
   logic         burst_last;
   logic         can_start;
   logic [N:0]   thresh;

   assign wrap       = (cnt_q == (sh_ticks_q - N'(1)));
   assign burst_last = (sh_mode_q == PULSE_BURST) && (rem_q == M'(1));
   assign can_start  = ch_ena && (ticks != '0) &&
                       ((mode == 1'b0) || (start && (burst_len != '0)));

   // Next-state: entry, ch_ena drop, wrap/reload, burst end, and ena stall.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_ticks_d = sh_ticks_q;
      sh_width_d = sh_width_q;
      sh_mode_d  = sh_mode_q;
      rem_d      = rem_q;
      done_d     = 1'b0;
      case (state_q)
         PULSE_IDLE: begin
            if (can_start) begin
               state_d    = PULSE_RUN;
               cnt_d      = '0;
               sh_ticks_d = ticks;
               sh_width_d = width;
               sh_mode_d  = pulse_mode_t'(mode);
               rem_d      = burst_len;
            end
         end
         PULSE_RUN: begin
            if (!ch_ena) begin
               // Disable wins over any wrap or burst end this cycle.
               state_d = PULSE_IDLE;
               cnt_d   = '0;
            end else if (ena) begin
               if (wrap) begin
                  cnt_d      = '0;
                  sh_ticks_d = ticks;
                  sh_width_d = width;
                  if (sh_mode_q == PULSE_BURST) rem_d = rem_q - M'(1);
                  if (burst_last) begin
                     state_d = PULSE_IDLE;
                     done_d  = 1'b1;
                  end else if (ticks == '0) begin
                     state_d = PULSE_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + N'(1);
               end
            end
         end
         default: state_d = PULSE_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= PULSE_IDLE;
         cnt_q      <= '0;
         sh_ticks_q <= '0;
         sh_width_q <= '0;
         sh_mode_q  <= PULSE_CONT;
         rem_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_ticks_q <= sh_ticks_d;
         sh_width_q <= sh_width_d;
         sh_mode_q  <= sh_mode_d;
         rem_q      <= rem_d;
         done_q     <= done_d;
      end
   end

   // High for the last width counts of the period; width >= ticks stays high.
   always_comb begin
      thresh = {1'b0, sh_ticks_q} - {1'b0, sh_width_q};
      out    = (state_q == PULSE_RUN) &&
               ((sh_width_q >= sh_ticks_q) || ({1'b0, cnt_q} >= thresh));
   end

   assign busy = (state_q == PULSE_RUN);
   assign done = done_q;

endmodule

// File: rtl/multi_pulse_generator.sv
// Multi-channel periodic pulse generator: CHANNELS independent pulse_channel
// instances sharing one global tick enable.
module multi_pulse_generator
   import pulse_pkg::*;
#(
   parameter int N        = 8,
   parameter int CHANNELS = 4,
   parameter int M        = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic [CHANNELS-1:0]   ch_ena,
   input  logic [CHANNELS-1:0]   mode,
   input  logic [CHANNELS-1:0]   start,
   input  logic [CHANNELS*N-1:0] ticks,
   input  logic [CHANNELS*N-1:0] width,
   input  logic [CHANNELS*M-1:0] burst_len,
   output logic [CHANNELS-1:0]   out,
   output logic [CHANNELS-1:0]   busy,
   output logic [CHANNELS-1:0]   done
);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      pulse_channel #(.N(N), .M(M)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .ena       (ena),
         .ch_ena    (ch_ena[c]),
         .mode      (mode[c]),
         .start     (start[c]),
         .ticks     (ticks[c*N +: N]),
         .width     (width[c*N +: N]),
         .burst_len (burst_len[c*M +: M]),
         .out       (out[c]),
         .busy      (busy[c]),
         .done      (done[c])
      );
   end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Bench for multi_pulse_generator: constant-table vectors on channel 0, a few
// hand-written corner sequences, then randomized traffic on all channels,
// every cycle compared against an integer reference model.
module tb_multi_pulse_generator;
   localparam int N = 8;
   localparam int C = 4;
   localparam int M = 8;

   logic           clk = 1'b0;
   logic           rst, ena;
   logic [C-1:0]   ch_ena, mode, start;
   logic [C*N-1:0] ticks, width;
   logic [C*M-1:0] burst_len;
   logic [C-1:0]   out, busy, done;

   always #5 clk = ~clk;

   multi_pulse_generator #(.N(N), .CHANNELS(C), .M(M)) dut (
      .clk(clk), .rst(rst), .ena(ena), .ch_ena(ch_ena), .mode(mode),
      .start(start), .ticks(ticks), .width(width), .burst_len(burst_len),
      .out(out), .busy(busy), .done(done)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: plain integers per channel.
   int m_run[C], m_cnt[C], m_per[C], m_wid[C], m_burst[C], m_left[C], m_done[C];

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int c = 0; c < C; c++) begin
         int t, w, bl, dn;
         t  = int'(ticks[c*N +: N]);
         w  = int'(width[c*N +: N]);
         bl = int'(burst_len[c*M +: M]);
         dn = 0;
         if (!rst) begin
            m_run[c] = 0; m_cnt[c] = 0; m_per[c] = 0; m_wid[c] = 0;
            m_burst[c] = 0; m_left[c] = 0;
         end else if (m_run[c] == 0) begin
            if (ch_ena[c] && t != 0 && (!mode[c] || (start[c] && bl != 0))) begin
               m_run[c] = 1; m_cnt[c] = 0; m_per[c] = t; m_wid[c] = w;
               m_burst[c] = int'(mode[c]); m_left[c] = bl;
            end
         end else if (!ch_ena[c]) begin
            m_run[c] = 0; m_cnt[c] = 0;
         end else if (ena) begin
            if (m_cnt[c] == m_per[c] - 1) begin
               bit last;
               last = (m_burst[c] == 1) && (m_left[c] == 1);
               m_cnt[c] = 0; m_per[c] = t; m_wid[c] = w;
               if (m_burst[c] == 1) m_left[c] = (m_left[c] + 255) % 256;
               if (last) begin
                  m_run[c] = 0; dn = 1;
               end else if (t == 0) begin
                  m_run[c] = 0;
               end
            end else begin
               m_cnt[c]++;
            end
         end
         m_done[c] = dn;
      end
   endtask

   function automatic logic [C-1:0] exp_out();
      logic [C-1:0] v;
      for (int c = 0; c < C; c++)
         v[c] = (m_run[c] != 0) && (m_cnt[c] >= m_per[c] - m_wid[c]);
      return v;
   endfunction

   function automatic logic [C-1:0] exp_busy();
      logic [C-1:0] v;
      for (int c = 0; c < C; c++) v[c] = (m_run[c] != 0);
      return v;
   endfunction

   function automatic logic [C-1:0] exp_done();
      logic [C-1:0] v;
      for (int c = 0; c < C; c++) v[c] = (m_done[c] != 0);
      return v;
   endfunction

   // One clock: model updates on the edge, outputs checked on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model_out",  int'(out),  int'(exp_out()));
      check("model_busy", int'(busy), int'(exp_busy()));
      check("model_done", int'(done), int'(exp_done()));
   endtask

   typedef struct {
      bit rst, ena, ce, md, st;
      int tk, wd, bl;
      bit eo, eb, ed;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(bit r, bit e, bit ce, bit md, bit st, int tk, int wd, int bl,
                               bit eo, bit eb, bit ed);
      vec_t v;
      v.rst = r; v.ena = e; v.ce = ce; v.md = md; v.st = st;
      v.tk = tk; v.wd = wd; v.bl = bl; v.eo = eo; v.eb = eb; v.ed = ed;
      return v;
   endfunction

   task automatic set_ch(input int c, input bit ce, input bit md, input bit st,
                         input int tk, input int wd, input int bl);
      ch_ena[c] = ce; mode[c] = md; start[c] = st;
      ticks[c*N +: N] = N'(tk); width[c*N +: N] = N'(wd); burst_len[c*M +: M] = M'(bl);
   endtask

   task automatic all_off();
      for (int c = 0; c < C; c++) set_ch(c, 1'b0, 1'b0, 1'b0, 0, 0, 0);
   endtask

   initial begin
      int pos[$];
      rst = 1'b0; ena = 1'b1;
      all_off();
      for (int c = 0; c < C; c++) begin
         m_run[c] = 0; m_cnt[c] = 0; m_per[c] = 0; m_wid[c] = 0;
         m_burst[c] = 0; m_left[c] = 0; m_done[c] = 0;
      end

      // Table: reset, legacy continuous (5/1 then 5/2), disable, burst 3/1 x2.
      tbl.push_back(mk(0,1,1,0,0,5,1,0, 0,0,0));
      tbl.push_back(mk(0,1,1,0,0,5,1,0, 0,0,0));
      tbl.push_back(mk(1,1,1,0,0,5,1,0, 0,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,1,0, 0,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,1,0, 0,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,1,0, 0,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,1,0, 1,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,1,0, 0,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,1,0, 0,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,1,0, 0,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,1,0, 0,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,1,0, 1,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,2,0, 0,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,2,0, 0,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,2,0, 0,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,2,0, 1,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,2,0, 1,1,0));
      tbl.push_back(mk(1,1,1,0,0,5,2,0, 0,1,0));
      tbl.push_back(mk(1,1,0,0,0,5,2,0, 0,0,0));
      tbl.push_back(mk(1,1,1,1,1,3,1,2, 0,1,0));
      tbl.push_back(mk(1,1,1,1,0,3,1,2, 0,1,0));
      tbl.push_back(mk(1,1,1,1,0,3,1,2, 1,1,0));
      tbl.push_back(mk(1,1,1,1,1,3,1,2, 0,1,0));
      tbl.push_back(mk(1,1,1,1,0,3,1,2, 0,1,0));
      tbl.push_back(mk(1,1,1,1,0,3,1,2, 1,1,0));
      tbl.push_back(mk(1,1,1,1,0,3,1,2, 0,0,1));
      tbl.push_back(mk(1,1,1,1,0,3,1,2, 0,0,0));

      foreach (tbl[i]) begin
         rst = tbl[i].rst; ena = tbl[i].ena;
         set_ch(0, tbl[i].ce, tbl[i].md, tbl[i].st, tbl[i].tk, tbl[i].wd, tbl[i].bl);
         tick();
         check($sformatf("tbl%0d_out", i),  int'(out[0]),  int'(tbl[i].eo));
         check($sformatf("tbl%0d_busy", i), int'(busy[0]), int'(tbl[i].eb));
         check($sformatf("tbl%0d_done", i), int'(done[0]), int'(tbl[i].ed));
      end
      all_off(); tick();

      // ticks==0 never starts a channel.
      set_ch(0, 1'b1, 1'b0, 1'b0, 0, 1, 0);
      repeat (3) begin tick(); check("ticks0_busy", int'(busy[0]), 0); end

      // ticks=1, width=1: constantly high while running.
      set_ch(0, 1'b1, 1'b0, 1'b0, 1, 1, 0);
      tick();
      repeat (4) begin tick(); check("ticks1_out", int'(out[0]), 1); end
      all_off(); tick();

      // width==0: busy but never high.
      set_ch(0, 1'b1, 1'b0, 1'b0, 3, 0, 0);
      repeat (5) begin
         tick();
         check("w0_out", int'(out[0]), 0);
         check("w0_busy", int'(busy[0]), 1);
      end
      all_off(); tick();

      // Shadow reload: period 4 changed to 6 mid-period.
      set_ch(2, 1'b1, 1'b0, 1'b0, 4, 1, 0);
      tick();
      ticks[2*N +: N] = N'(6);
      for (int i = 1; i < 12; i++) begin
         tick();
         if (out[2]) pos.push_back(i);
      end
      check("reload_npulses", pos.size(), 2);
      if (pos.size() >= 2) begin
         check("reload_first", pos[0], 3);
         check("reload_second", pos[1], 9);
      end
      all_off(); tick();

      // Stall: ena low for 3 cycles mid-period (model compares every cycle).
      set_ch(0, 1'b1, 1'b0, 1'b0, 5, 2, 0);
      repeat (2) tick();
      ena = 1'b0;
      repeat (3) begin tick(); check("stall_busy", int'(busy[0]), 1); end
      ena = 1'b1;
      repeat (4) tick();
      all_off(); tick();

      // ch_ena dropped mid-burst: IDLE next cycle, no done.
      set_ch(1, 1'b1, 1'b1, 1'b1, 3, 1, 3);
      tick();
      start[1] = 1'b0;
      repeat (4) tick();
      ch_ena[1] = 1'b0;
      tick();
      check("drop_busy", int'(busy[1]), 0);
      check("drop_done", int'(done[1]), 0);
      tick();
      check("drop_done2", int'(done[1]), 0);

      // Randomized concurrent traffic on all channels.
      for (int c = 0; c < C; c++)
         set_ch(c, 1'b1, 1'b0, 1'b0, c + 2, 1, 2);
      for (int k = 0; k < 800; k++) begin
         rst = ($urandom_range(0, 99) != 0);
         ena = ($urandom_range(0, 4) != 0);
         for (int c = 0; c < C; c++) begin
            if ($urandom_range(0, 7) == 0) begin
               ticks[c*N +: N] = N'($urandom_range(0, 6));
               width[c*N +: N] = N'($urandom_range(0, 7));
               burst_len[c*M +: M] = M'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) mode[c] = 1'($urandom_range(0, 1));
            ch_ena[c] = ($urandom_range(0, 15) != 0);
            start[c]  = ($urandom_range(0, 3) == 0);
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_pulse_generator.md
Name: multi_pulse_generator

Overview:
Parametrised, multi-channel successor to the single-channel periodic tick generator. Each channel produces a periodic pulse with a programmable period and high width, in continuous or counted-burst mode. Configuration is shadow-latched at period boundaries so outputs never glitch. Used as the shared timing source for PWM, strobe and sample-tick consumers.

Parameters:
N, 8, counter/period/width bit width
CHANNELS, 4, number of independent channels
M, 8, burst length counter width

Ports:
clk  in  1  clock, all logic posedge
rst  in  1  synchronous reset, active-low (asserted when 0)
ena  in  1  global tick enable; 0 freezes every channel's counter
ch_ena  in  CHANNELS  per-channel enable
mode  in  CHANNELS  per-channel mode: 0 continuous, 1 burst
start  in  CHANNELS  per-channel burst start request (single-cycle)
ticks  in  CHANNELS*N  per-channel period in ena cycles; channel c at [c*N +: N]
width  in  CHANNELS*N  per-channel high width in counts
burst_len  in  CHANNELS*M  per-channel periods per burst
out  out  CHANNELS  pulse outputs
busy  out  CHANNELS  channel in RUN state
done  out  CHANNELS  one-cycle pulse when a burst completes

Behaviour:
- Reset (rst==0 at posedge): all states IDLE, counters 0, shadows 0, busy/done 0; out therefore 0.
- Per-channel FSM, IDLE/RUN, independent of other channels.
- IDLE->RUN at posedge when ch_ena && ticks!=0 and either (mode==0) or (mode==1 && start && burst_len!=0). On entry: counter<=0, shadow_ticks/width/mode<=inputs, remaining<=burst_len.
- In RUN with ena==1: if counter==shadow_ticks-1 (wrap): counter<=0, reload shadow_ticks/width from inputs; if shadow_mode==1, remaining<=remaining-1. Otherwise counter<=counter+1. With ena==0 all state holds.
- Burst end: wrap with shadow_mode==1 and remaining==1 -> IDLE; done high for exactly the following cycle.
- Reload with new ticks==0 -> IDLE, no done.
- ch_ena==0 in RUN -> IDLE next posedge, counter<=0, no done; has priority over wrap and burst end.
- start ignored in RUN and when mode==0. mode input ignored in RUN (shadow_mode governs).
- out (combinational from registers): state==RUN && counter >= shadow_ticks - shadow_width, compare in N+1 bits; width>=ticks -> constantly high in RUN; width==0 -> never high. width==1 gives one high cycle per period at counter==ticks-1, matching the legacy generator.
- ticks==1: counter stays 0, wraps every ena cycle.
- busy == (state==RUN), registered.
- Changing ticks/width mid-period has no effect until next wrap.
- Reset mid-burst: immediate IDLE, done not asserted.

Decomposition:
- Package pulse_pkg: pulse_mode_t enum {PULSE_CONT, PULSE_BURST}, pulse_state_t enum {PULSE_IDLE, PULSE_RUN}.
- Sub-module pulse_channel (one channel: FSM, counter, shadows, remaining, out/busy/done); top instantiates CHANNELS copies in a generate loop and slices the packed buses.

Test Plan:
- Reset/default: rst=0 for 2 cycles, any inputs -> out=0, busy=0, done=0.
- Continuous legacy: ch0 ticks=5, width=1, ena=1 -> out[0] high one cycle every 5 clocks, counter 4; width=2 -> high at counts 3,4.
- Burst: ch1 mode=1, ticks=3, width=1, burst_len=2, start pulse -> exactly 2 out pulses, busy high 6 cycles, done 1 cycle after final wrap; start while busy ignored.
- Shadow reload: ch2 ticks=4 running, change ticks to 6 mid-period -> current period ends at 4, next at 6; width>=ticks -> constant high.
- Stall and disable: ena toggled 0 for 3 cycles -> counters/out hold; ch_ena dropped mid-burst -> IDLE next cycle, no done.
- Edges: ticks=0 -> never enters RUN; ticks=1,width=1 -> out constantly high; width=0 -> out stays 0 while busy=1; all channels run concurrently with differing ticks.
